attn_ram_pingpong: RTL

ATTN_RAM_PINGPONG -- requirements
Module: attn_ram_pingpong

---
 rtl/attn_ram_pingpong.sv | 103 ++++++++++
 1 files changed

// File: rtl/attn_ram_pingpong.sv
// Double-buffered attention-score frame store. The producer fills one bank
// while the consumer reads the other. A frame is released two cycles after Done.
module attn_ram_pingpong #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              s_clk,
    input  logic              s_rst,
    input  logic              i_attn_valid,
    input  logic [DATA_W-1:0] i_attn_data,
    output logic              o_attn_ready,
    input  logic [ADDR_W-1:0] i_AttnRam_rd_addr,
    output logic [DATA_W-1:0] o_AttnRAM_data,
    output logic              o_AttnRAM_Empty,
    input  logic              i_AttnRam_Done,
    output logic              o_proto_err
);

    typedef enum logic {W_FILL, W_WAIT} wstate_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    wstate_e           wstate_q, wstate_d;
    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]        rel_q, rel_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q;
    logic              accept;
    logic              done_ok;
    logic [DATA_W-1:0] mem_q [2*DEPTH];

    assign o_attn_ready    = (wstate_q == W_FILL) && !full_q[wr_bank_q];
    assign o_AttnRAM_Empty = !full_q[rd_bank_q];
    assign o_AttnRAM_data  = rdata_q;
    assign o_proto_err     = err_q;

    assign accept  = i_attn_valid && o_attn_ready;
    assign done_ok = i_AttnRam_Done && (rel_q == 2'b00) && full_q[rd_bank_q];

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_addr_d = wr_addr_q;
        wstate_d  = wstate_q;
        rel_d     = {rel_q[0], done_ok};
        err_d     = err_q | (i_AttnRam_Done & ~done_ok);

        if (accept) begin
            wr_addr_d = wr_addr_q + 1'b1;
            if (wr_addr_q == LAST_ADDR) begin
                wr_addr_d         = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        // Release is applied after the frame-complete set so it wins a same-bank collision.
        if (rel_q[1]) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end

        case (wstate_q)
            W_FILL: if (accept && (wr_addr_q == LAST_ADDR) && full_d[wr_bank_d]) wstate_d = W_WAIT;
            W_WAIT: if (!full_q[wr_bank_q]) wstate_d = W_FILL;
            default: wstate_d = W_FILL;
        endcase
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            wstate_q  <= W_FILL;
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_addr_q <= '0;
            rel_q     <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            wstate_q  <= wstate_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_addr_q <= wr_addr_d;
            rel_q     <= rel_d;
            err_q     <= err_d;
            rdata_q   <= mem_q[{rd_bank_q, i_AttnRam_rd_addr}];
        end
    end

    always_ff @(posedge s_clk) begin
        if (accept) begin
            mem_q[{wr_bank_q, wr_addr_q}] <= i_attn_data;
        end
    end

endmodule
